// File: rtl/fetch_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue_if                                                           |
// | Fetch-to-decode handshake bundle used by fetch_queue.                    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface fetch_queue_if #(
  parameter int AW = 2
) ();
  logic [31:0] instrf;
  logic [31:0] pcf;
  logic        pcchangef;
  logic        stallf;
  logic [31:0] instrd;
  logic [31:0] pcd;
  logic        validd;
  logic        readyd;
  logic [AW:0] occd;

  // Queue side.
  modport slave (
    input  instrf, pcf, pcchangef, readyd,
    output stallf, instrd, pcd, validd, occd
  );

  // Fetch/decode side.
  modport master (
    output instrf, pcf, pcchangef, readyd,
    input  stallf, instrd, pcd, validd, occd
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue                                                              |
// | FIFO between fetch and decode: stalls fetch when full, flushes on a PC   |
// | redirect. Optional macro FETCH_QUEUE_BYPASS_EN forwards into empty queue.|
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_bypass;
  logic [63:0]   w_head;

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rptr];

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass   = w_empty && !bus.pcchangef;
  assign bus.validd = !w_empty || w_bypass;
  assign bus.instrd = w_bypass ? bus.instrf : (w_empty ? 32'd0 : w_head[63:32]);
  assign bus.pcd    = w_bypass ? bus.pcf    : (w_empty ? 32'd0 : w_head[31:0]);
`else
  assign w_bypass   = 1'b0;
  assign bus.validd = !w_empty;
  assign bus.instrd = w_empty ? 32'd0 : w_head[63:32];
  assign bus.pcd    = w_empty ? 32'd0 : w_head[31:0];
`endif

  // A forwarded word taken by decode this cycle never occupies a slot.
  assign w_push = !bus.pcchangef && !w_full && !(w_bypass && bus.readyd);
  assign w_pop  = !w_empty && bus.readyd;

  assign bus.stallf = w_full && !bus.pcchangef;
  assign bus.occd   = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.instrf, bus.pcf};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.pcchangef) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_queue                                                           |
// | Directed + random stimulus against a queue-based reference model.        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk;
  logic reset;

  fetch_queue_if #(.AW(AW)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [63:0] q [$];
  logic [31:0] cur_pc;
  logic [31:0] cur_instr;

  logic        exp_valid;
  logic        exp_stall;
  logic [31:0] exp_instr;
  logic [31:0] exp_pc;
  logic [31:0] exp_occ;
  logic        exp_byp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs from the queue contents and the current inputs.
  task automatic predict(input logic chg);
    exp_occ   = 32'(q.size());
    exp_stall = (q.size() == DEPTH) && !chg;
    exp_byp   = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    exp_byp   = (q.size() == 0) && !chg;
`endif
    if (exp_byp) begin
      exp_valid = 1'b1;
      exp_instr = cur_instr;
      exp_pc    = cur_pc;
    end else if (q.size() != 0) begin
      exp_valid = 1'b1;
      exp_instr = q[0][63:32];
      exp_pc    = q[0][31:0];
    end else begin
      exp_valid = 1'b0;
      exp_instr = 32'd0;
      exp_pc    = 32'd0;
    end
  endtask

  task automatic check_outputs(input logic chg);
    predict(chg);
    chk("validd", {31'd0, bus.validd}, {31'd0, exp_valid});
    chk("stallf", {31'd0, bus.stallf}, {31'd0, exp_stall});
    chk("occd",   {29'd0, bus.occd},   exp_occ);
    chk("instrd", bus.instrd, exp_instr);
    chk("pcd",    bus.pcd,    exp_pc);
  endtask

  // One clock cycle: drive, check mid-cycle, advance model, advance clock.
  task automatic step(input logic chg, input logic [31:0] tgt, input logic rdy, input logic upd);
    bus.instrf    = cur_instr;
    bus.pcf       = cur_pc;
    bus.pcchangef = chg;
    bus.readyd    = rdy;
    #1;
    check_outputs(chg);
    if (upd) begin
      if (chg) begin
        q.delete();
        cur_pc    = tgt;
        cur_instr = $urandom;
      end else begin
        if (!(exp_byp && rdy)) begin
          if (exp_valid && rdy) void'(q.pop_front());
          if (!exp_stall) q.push_back({cur_instr, cur_pc});
        end
        if (!exp_stall) begin
          cur_pc    = cur_pc + 32'd4;
          cur_instr = $urandom;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    cur_pc        = 32'h0;
    cur_instr     = $urandom;
    bus.instrf    = 32'd0;
    bus.pcf       = 32'd0;
    bus.pcchangef = 1'b0;
    bus.readyd    = 1'b1;
    @(posedge clk);
    #1;

    // Held in reset.
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
    reset = 1'b1;

    // Fill to full and stall on 0x10, then drain in order.
    for (int i = 0; i < 7; i++) step(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1, 1'b1);

    // Streaming with pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b0, 32'd0, 1'b1, 1'b1);

    // Load 0x20..0x2C, redirect while presenting 0x30 (queue full).
    step(1'b1, 32'h20, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 32'h400, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1, 1'b1);

    // Back-to-back redirects.
    step(1'b1, 32'h500, 1'b1, 1'b1);
    step(1'b1, 32'h600, 1'b1, 1'b1);
    step(1'b1, 32'h700, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 7) == 0), {$urandom_range(0, 4095), 2'b00} & 32'h3FFC,
           $urandom_range(0, 2) != 0, 1'b1);
    end

    // Build occupancy 3, then assert reset between edges.
    step(1'b1, 32'h900, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("occ_before_reset", {29'd0, bus.occd}, 32'd3);
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    check_outputs(bus.pcchangef);
    @(posedge clk);
    #1;
    check_outputs(bus.pcchangef);
    reset     = 1'b1;
    cur_pc    = 32'hA00;
    cur_instr = $urandom;
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, $urandom_range(0, 1) != 0, 1'b1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
